// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcode/funct constants and control encodings for mc_main_ctrl
package mc_pkg;

  // Controller states; encodings 14 and 15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTYPE  = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDI   = 4'd9,
    LOGI   = 4'd10,
    IMMWB  = 4'd11,
    JUMP   = 4'd12,
    BNE    = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - op/funct to ALU control decode with unsupported-funct flag
import mc_pkg::*;

module mc_alu_dec #(
  parameter int OPW   = 6,
  parameter int ALUCW = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [OPW-1:0]   funct,
  output logic [ALUCW-1:0] alu_ctrl,
  output logic             funct_bad
);

  // R-type uses funct, logical immediates use op, everything else adds
  always_comb begin
    alu_ctrl  = ALU_ADD;
    funct_bad = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: funct_bad = 1'b1;
        endcase
      end
      OP_ANDI: alu_ctrl = ALU_AND;
      OP_ORI:  alu_ctrl = ALU_OR;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// rtl/mc_main_ctrl.sv - multi-cycle MIPS main controller FSM; MC_BNE_EN adds bne and pc_write_cond_n
import mc_pkg::*;

module mc_main_ctrl #(
  parameter int OPW   = 6,
  parameter int ALUCW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   op,
  input  logic [OPW-1:0]   funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
`ifdef MC_BNE_EN
  output logic             pc_write_cond_n,
`endif
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [ALUCW-1:0] alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             ext_zero,
  output logic             illegal,
  output logic [3:0]       state_o
);

  state_t             state, state_nxt;
  logic               ext_flag;
  logic [ALUCW-1:0]   dec_ctrl;
  logic               dec_bad;

  mc_alu_dec #(.OPW(OPW), .ALUCW(ALUCW)) u_alu_dec (
    .op        (op),
    .funct     (funct),
    .alu_ctrl  (dec_ctrl),
    .funct_bad (dec_bad)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  // Remember the extender mode so IMMWB keeps the extender output stable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ext_flag <= 1'b0;
    else      ext_flag <= ext_zero;
  end

  // Next-state and Moore strobes; enables are squashed while in reset
  always_comb begin
    state_nxt     = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
`ifdef MC_BNE_EN
    pc_write_cond_n = 1'b0;
`endif
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_ctrl      = ALU_ADD;
    pc_src        = PCSRC_ALU;
    ext_zero      = 1'b0;
    illegal       = 1'b0;

    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        state_nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (op)
          OP_RTYPE:      state_nxt = RTYPE;
          OP_LW, OP_SW:  state_nxt = MEMADR;
          OP_BEQ:        state_nxt = BEQ;
`ifdef MC_BNE_EN
          OP_BNE:        state_nxt = BNE;
`endif
          OP_ADDI:       state_nxt = ADDI;
          OP_ANDI, OP_ORI: state_nxt = LOGI;
          OP_J:          state_nxt = JUMP;
          default: begin
            illegal   = 1'b1;
            state_nxt = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_nxt = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b1;
        state_nxt = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_nxt = mem_ready ? FETCH : MEMWR;
      end
      RTYPE: begin
        alu_src_a = 1'b1;
        alu_ctrl  = dec_ctrl;
        illegal   = dec_bad;
        state_nxt = dec_bad ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_nxt = FETCH;
      end
      BEQ: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        state_nxt     = FETCH;
      end
`ifdef MC_BNE_EN
      BNE: begin
        alu_src_a       = 1'b1;
        alu_ctrl        = ALU_SUB;
        pc_write_cond_n = 1'b1;
        pc_src          = PCSRC_ALUOUT;
        state_nxt       = FETCH;
      end
`endif
      ADDI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        state_nxt = IMMWB;
      end
      LOGI: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_zero  = 1'b1;
        alu_ctrl  = dec_ctrl;
        state_nxt = IMMWB;
      end
      IMMWB: begin
        reg_write = 1'b1;
        ext_zero  = ext_flag;
        state_nxt = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_src    = PCSRC_JUMP;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    if (!rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
`ifdef MC_BNE_EN
      pc_write_cond_n = 1'b0;
`endif
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
- Multi-cycle MIPS main controller. It sequences the shared datapath (PC, IR, register file, ALU, immediate extender, unified memory) one state per cycle.
- Decodes op/funct latched in IR and drives Moore-style control strobes.
- Drives the extender select: zero-extend for logical immediates, sign-extend otherwise.
- Stalls on a memory-ready handshake.

Parameters:
- OPW, 6, opcode/funct width
- ALUCW, 3, ALU control width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  OPW  IR[31:26]
- funct  in  OPW  IR[5:0]
- mem_ready  in  1  memory completed current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback source: 1=MDR, 0=ALUOut
- reg_dst  out  1  dest: 1=rd, 0=rt
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- alu_ctrl  out  ALUCW  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
- ext_zero  out  1  to extender: 1=zero-extend, 0=sign-extend
- illegal  out  1  one-cycle pulse on unsupported op/funct
- state_o  out  4  current state (debug)

Behaviour:
- State register only; outputs are a combinational decode of state, with mem_ready gating where noted. Unlisted outputs are 0. Default alu_ctrl is 010; default ext_zero is 0.
- Reset (rst=0): state=FETCH asynchronously. While rst=0, all enables are forced to 0: pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write, illegal. The first FETCH request is issued on the first cycle after release.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_src=00.
  - pc_write=ir_write=mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11 (branch target precompute). Next state by op:
  - 000000 -> RTYPE
  - 100011 or 101011 -> MEMADR
  - 000100 -> BEQ
  - 001000 -> ADDI
  - 001100 or 001101 -> LOGI
  - 000010 -> JUMP
  - any other op -> FETCH with illegal=1
- MEMADR: alu_src_a=1, alu_src_b=10. op=100011 -> MEMRD, else -> MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, i_or_d=1. Holds until mem_ready, then -> FETCH. mem_write stays high through the wait.
- RTYPE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Any other funct: illegal=1 and -> FETCH without writeback; otherwise -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_ctrl=110, pc_write_cond=1, pc_src=01 -> FETCH.
- ADDI: alu_src_a=1, alu_src_b=10, ext_zero=0, alu_ctrl=010 -> IMMWB.
- LOGI: alu_src_a=1, alu_src_b=10, ext_zero=1. alu_ctrl=000 for 001100 (andi), 001 for 001101 (ori). -> IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - ext_zero is held from the previous state so the extender stays stable. This requires a 1-bit registered flag, cleared on reset.
- JUMP: pc_write=1, pc_src=10 -> FETCH.
- op is sampled only in DECODE, MEMADR, RTYPE and LOGI; the IR holds it stable after FETCH.
- Unused state encodings -> FETCH next cycle with all enables 0.
- Latency (zero-wait memory): R-type/addi/andi/ori/sw 4 cycles, lw 5, beq 3, j 3. Each mem_ready=0 cycle adds 1.

Optional Feature:
- MC_BNE_EN defined:
  - op 000101 -> BNE state, same as BEQ but with a pc_write_cond_n output asserted (PC load if ALU not zero).
  - pc_write_cond_n is an extra 1-bit output, present only when the macro is defined.
- MC_BNE_EN undefined: op 000101 is illegal; the pc_write_cond_n port does not exist.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J
  - funct constants
  - alu_ctrl encodings
  - alu_src_b and pc_src encodings
- One sub-module, mc_alu_dec: combinational funct/op -> alu_ctrl plus an illegal-funct flag.

Test Plan:
- Reset: hold rst=0 for 3 cycles with mem_ready=1 -> all enables 0, state_o=FETCH. After release: mem_read=1, pc_write=ir_write=1 in the same cycle.
- add (op=0, funct=100000), mem_ready=1 -> FETCH, DECODE, RTYPE (alu_ctrl=010), ALUWB (reg_write=1, reg_dst=1); FETCH again at cycle 5.
- lw (op=100011) with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with mem_read=1, i_or_d=1; MEMWB reg_write=1, mem_to_reg=1; total 7 cycles.
- andi (op=001100) -> ext_zero=1 in LOGI and IMMWB, alu_ctrl=000. addi (op=001000) -> ext_zero=0, alu_ctrl=010.
- beq (op=000100) -> BEQ: pc_write_cond=1, alu_ctrl=110, pc_src=01; back in FETCH at cycle 4.
- op=111111, then op=0 with funct=000000 -> illegal=1 for exactly one cycle each (DECODE and RTYPE respectively), reg_write never asserted, return to FETCH. With MC_BNE_EN: op=000101 -> pc_write_cond_n=1.
